ps2_key_decoder: RTL and testbench

//   Receives PS/2 keyboard frames (device-to-host only) and turns set-2 scan codes into held-key

---
 rtl/ps2_key_decoder.sv | 102 ++++++++++
 tb/tb_ps2_key_decoder.sv | 111 +++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 device-to-host receiver turning set-2 scan codes into held-key levels
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err,
  output logic       shoot,
  output logic       forward,
  output logic       rotate_left,
  output logic       rotate_right
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] TO_MAX = W'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t r_state, w_next;
  logic [1:0] r_clk_s, r_dat_s;
  logic r_clk_prev, r_par, r_ext, r_brk, r_scan_valid, r_frame_err;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_data, r_scan_code;
  logic [6:0] r_held, w_hit;
  logic [W-1:0] r_idle_cnt;
  logic w_fall, w_dat, w_to, w_good, w_bad;
  assign w_fall = r_clk_prev & ~r_clk_s[1];
  assign w_dat  = r_dat_s[1];
  assign w_to   = (r_state != IDLE) && !w_fall && (r_idle_cnt == TO_MAX);
  assign w_good = (r_state == STOP) && w_fall && (^r_data ^ r_par) && w_dat;
  assign w_bad  = (r_state == STOP) && w_fall && !((^r_data ^ r_par) && w_dat);
  // Bit order matches held[6:0]: D, Right, A, Left, W, Up, Space
  assign w_hit = {{r_ext, r_scan_code} == 9'h023, {r_ext, r_scan_code} == 9'h174,
                  {r_ext, r_scan_code} == 9'h01C, {r_ext, r_scan_code} == 9'h16B,
                  {r_ext, r_scan_code} == 9'h01D, {r_ext, r_scan_code} == 9'h175,
                  {r_ext, r_scan_code} == 9'h029};
  always_comb begin
    w_next = r_state;
    if (w_to)
      w_next = IDLE;
    else if (w_fall)
      case (r_state)
        IDLE:    w_next = w_dat ? IDLE : DATA;
        DATA:    w_next = (r_bit_cnt == 3'd7) ? PARITY : DATA;
        PARITY:  w_next = STOP;
        default: w_next = IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s      <= '0;
      r_dat_s      <= '0;
      r_clk_prev   <= 1'b0;
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_data       <= '0;
      r_par        <= 1'b0;
      r_idle_cnt   <= '0;
      r_scan_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_scan_code  <= '0;
      r_ext        <= 1'b0;
      r_brk        <= 1'b0;
      r_held       <= '0;
    end else begin
      r_clk_s      <= {r_clk_s[0], ps2_clk_in};
      r_dat_s      <= {r_dat_s[0], ps2_dat_in};
      r_clk_prev   <= r_clk_s[1];
      r_state      <= w_next;
      r_idle_cnt   <= (w_fall || r_state == IDLE) ? '0 : r_idle_cnt + W'(1);
      r_scan_valid <= w_good;
      r_frame_err  <= w_bad | w_to;
      if (w_fall && r_state == IDLE) r_bit_cnt <= '0;
      if (w_fall && r_state == DATA) begin
        r_data[r_bit_cnt] <= w_dat;
        r_bit_cnt         <= r_bit_cnt + 3'd1;
      end
      if (w_fall && r_state == PARITY) r_par <= w_dat;
      if (w_good) r_scan_code <= r_data;
      if (r_frame_err) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (r_scan_valid) begin
        if (r_scan_code == 8'hE0) r_ext <= 1'b1;
        else if (r_scan_code == 8'hF0) r_brk <= 1'b1;
        else begin
          r_held <= r_brk ? (r_held & ~w_hit) : (r_held | w_hit);
          r_ext  <= 1'b0;
          r_brk  <= 1'b0;
        end
      end
    end
  end
  assign scan_valid   = r_scan_valid;
  assign scan_code    = r_scan_code;
  assign frame_err    = r_frame_err;
  assign shoot        = r_held[0];
  assign forward      = r_held[1] | r_held[2];
  assign rotate_left  = r_held[3] | r_held[4];
  assign rotate_right = r_held[5] | r_held[6];
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed PS/2 frames with hand-computed expected key levels and pulses
module tb_ps2_key_decoder;
  logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1;
  logic scan_valid, frame_err, shoot, forward, rotate_left, rotate_right;
  logic [7:0] scan_code;
  int n_chk = 0, n_fail = 0, cyc = 0, n_sv = 0, n_err = 0, sv_cyc = 0, sh_cyc = 0;
  int sv0, err0;
  logic shoot_q = 1'b0;
  ps2_key_decoder #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .ps2_clk_in(ps2_clk), .ps2_dat_in(ps2_dat),
    .scan_valid(scan_valid), .scan_code(scan_code), .frame_err(frame_err),
    .shoot(shoot), .forward(forward), .rotate_left(rotate_left), .rotate_right(rotate_right)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (scan_valid) begin
      n_sv   <= n_sv + 1;
      sv_cyc <= cyc;
    end
    if (frame_err) n_err <= n_err + 1;
    if (shoot && !shoot_q) sh_cyc <= cyc;
    shoot_q <= shoot;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic bad_par = 1'b0, input logic bad_stop = 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ bad_par);
    ps2_bit(~bad_stop);
    ps2_dat = 1'b1;
    repeat (10) @(negedge clk);
  endtask
  task automatic send_partial(input logic [7:0] b, input int n);
    ps2_bit(1'b0);
    for (int i = 0; i < n; i++) ps2_bit(b[i]);
    ps2_dat = 1'b1;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_code", scan_code, 8'h00);
    check("rst_keys", {shoot, forward, rotate_left, rotate_right}, 4'b0000);
    check("rst_pulses", n_sv + n_err, 0);
    send(8'h29);
    check("sv_cnt", n_sv, 1);
    check("code29", scan_code, 8'h29);
    check("shoot_on", shoot, 1'b1);
    check("latency", sh_cyc - sv_cyc, 1);
    send(8'hF0); send(8'h29);
    check("shoot_off", shoot, 1'b0);
    check("sv_cnt3", n_sv, 3);
    send(8'hE0); send(8'h75);
    check("fwd_up", forward, 1'b1);
    send(8'h1D);
    check("fwd_w", forward, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("fwd_alias", forward, 1'b1);
    send(8'hF0); send(8'h1D);
    check("fwd_off", forward, 1'b0);
    check("no_err", n_err, 0);
    sv0 = n_sv;
    send(8'h29, 1'b1, 1'b0);
    check("par_err", n_err, 1);
    check("par_nosv", n_sv, sv0);
    check("par_shoot", shoot, 1'b0);
    send(8'h29, 1'b0, 1'b1);
    check("stop_err", n_err, 2);
    check("stop_nosv", n_sv, sv0);
    check("stop_shoot", shoot, 1'b0);
    send(8'hE0);
    send_partial(8'h6B, 4);
    repeat (150) @(negedge clk);
    check("to_err", n_err, 3);
    send(8'h6B);
    check("to_code", scan_code, 8'h6B);
    check("to_keys", {shoot, forward, rotate_left, rotate_right}, 4'b0000);
    send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74);
    check("both_lr", {rotate_left, rotate_right}, 2'b11);
    sv0 = n_sv;
    err0 = n_err;
    send_partial(8'h23, 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_rst_keys", {shoot, forward, rotate_left, rotate_right}, 4'b0000);
    check("mid_rst_code", scan_code, 8'h00);
    check("mid_rst_pulses", (n_sv - sv0) + (n_err - err0), 0);
    send(8'h23);
    check("post_rst_d", {rotate_left, rotate_right}, 2'b01);
    check("post_rst_code", scan_code, 8'h23);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_fail);
    $finish;
  end
endmodule
